// File: rtl/fburg_pkg.sv
// Shared definitions for the host/internal register-port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fburg_pkg;

   // Arbiter FSM encoding.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HACC  = 3'd1,
      HRD   = 3'd2,
      HDONE = 3'd3,
      IACC  = 3'd4,
      IRESP = 3'd5
   } state_t;

   // Read data handed back to the host for any rejected read.
   localparam logic [15:0] ERR_DATA_DFLT = 16'hdead;

   // Host byte address whose legal write clears the sticky Int flag.
   localparam logic [11:0] INT_CLR_ADDR = 12'h000;

endpackage

// File: rtl/fburg_sync2.sv
// Two-flop synchronizer for one active-low asynchronous strobe.
// Latency: 2 Clk cycles from d to q.
// Backpressure: none; samples every cycle.
// Ports: Clk, Reset (sync, active-high, forces q=1), d (async in), q (synced out).
module fburg_sync2 (
   input  logic Clk,
   input  logic Reset,
   input  logic d,
   output logic q
);

   logic meta;

   // Reset value is 1 so that strobes read as inactive until really seen low.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/fburg_bus_arb.sv
// Arbitrates one shared 16-bit register port between an async host bus and an internal requester.
// Latency: host write 2 / read 3 cycles from synced strobe to WaitN release; internal read data 1 cycle after IGnt.
// Backpressure: host held off with WaitN low; internal requester holds IReq until the IGnt pulse.
// Ports: Clk/Reset; host side Addr, DataIn, DataOut, DataOe, Cs, Rd, Wr, WaitN, WaitOe, Int;
//        internal side IReq, IWe, IAddr, IWdata, IGnt, IValid, IRdata;
//        register port RegEn, RegWe, RegAddr, RegWdata, RegRdata (read data one cycle after RegEn).
module fburg_bus_arb
   import fburg_pkg::*;
#(
   parameter int          REG_AW   = 6,
   parameter logic [15:0] ERR_DATA = ERR_DATA_DFLT
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [11:0]       Addr,
   input  logic [15:0]       DataIn,
   output logic [15:0]       DataOut,
   output logic              DataOe,
   input  logic              Cs,
   input  logic              Rd,
   input  logic              Wr,
   output logic              WaitN,
   output logic              WaitOe,
   output logic              Int,
   input  logic              IReq,
   input  logic              IWe,
   input  logic [REG_AW-1:0] IAddr,
   input  logic [15:0]       IWdata,
   output logic              IGnt,
   output logic              IValid,
   output logic [15:0]       IRdata,
   output logic              RegEn,
   output logic              RegWe,
   output logic [REG_AW-1:0] RegAddr,
   output logic [15:0]       RegWdata,
   input  logic [15:0]       RegRdata
);

   state_t            state;
   state_t            state_nxt;
   logic              cs_s;
   logic              rd_s;
   logic              wr_s;
   logic              last_int;    // 1: the internal side was granted most recently
   logic [11:0]       addr_q;
   logic [15:0]       wdat_q;
   logic              hwr_q;
   logic              iwe_q;
   logic              host_req;
   logic              host_conf;
   logic              host_win;
   logic              strobes_idle;
   logic              addr_ok;
   logic [REG_AW-1:0] haddr_w;

   fburg_sync2 u_sync_cs (.Clk(Clk), .Reset(Reset), .d(Cs), .q(cs_s));
   fburg_sync2 u_sync_rd (.Clk(Clk), .Reset(Reset), .d(Rd), .q(rd_s));
   fburg_sync2 u_sync_wr (.Clk(Clk), .Reset(Reset), .d(Wr), .q(wr_s));

   // Read enable on the raw pins so the host sees its bus driven without sync delay.
   assign DataOe = ~Cs & ~Rd;

   // Exactly one of Rd/Wr low is a normal cycle; both low is a protocol
   // error that still competes for the port so it gets flagged once.
   assign host_req     = !cs_s && (rd_s != wr_s);
   assign host_conf    = !cs_s && !rd_s && !wr_s;
   assign host_win     = (host_req || host_conf) && (!IReq || last_int);
   assign strobes_idle = cs_s && rd_s && wr_s;

   assign haddr_w = addr_q[REG_AW:1];
   assign addr_ok = !addr_q[0] && ((addr_q >> (REG_AW + 1)) == '0);

   assign IRdata = RegRdata;

   // State register.
   always_ff @(posedge Clk) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (host_win)  state_nxt = host_conf ? HDONE : HACC;
            else if (IReq) state_nxt = IACC;
         end
         HACC:    state_nxt = (addr_ok && !hwr_q) ? HRD : HDONE;
         HRD:     state_nxt = HDONE;
         // Wait for the host to end its bus cycle so one cycle is one access.
         HDONE:   if (strobes_idle) state_nxt = IDLE;
         IACC:    state_nxt = IRESP;
         IRESP:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic; everything is quiet while Reset is held.
   always_comb begin
      WaitN    = 1'b1;
      WaitOe   = 1'b0;
      RegEn    = 1'b0;
      RegWe    = 1'b0;
      RegAddr  = '0;
      RegWdata = '0;
      IGnt     = 1'b0;
      IValid   = 1'b0;
      if (!Reset) begin
         case (state)
            IDLE: begin
               // Start holding the host off in the very cycle it wins.
               if (host_win) begin
                  WaitOe = 1'b1;
                  WaitN  = 1'b0;
               end
            end
            HACC: begin
               WaitOe   = 1'b1;
               WaitN    = 1'b0;
               RegEn    = addr_ok;
               RegWe    = addr_ok && hwr_q;
               RegAddr  = haddr_w;
               RegWdata = wdat_q;
            end
            HRD: begin
               WaitOe = 1'b1;
               WaitN  = 1'b0;
            end
            HDONE: WaitOe = !strobes_idle;
            IACC: begin
               RegEn    = 1'b1;
               RegWe    = IWe;
               RegAddr  = IAddr;
               RegWdata = IWdata;
               IGnt     = 1'b1;
            end
            IRESP:   IValid = !iwe_q;
            default: ;
         endcase
      end
   end

   // Datapath: host capture, read-data register, error flag, round-robin memory.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         DataOut  <= '0;
         Int      <= 1'b0;
         last_int <= 1'b1;
         addr_q   <= '0;
         wdat_q   <= '0;
         hwr_q    <= 1'b0;
         iwe_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (host_win) begin
                  addr_q   <= Addr;
                  wdat_q   <= DataIn;
                  hwr_q    <= !wr_s;
                  last_int <= 1'b0;
                  if (host_conf) begin
                     Int     <= 1'b1;
                     DataOut <= ERR_DATA;
                  end
               end else if (IReq) begin
                  last_int <= 1'b1;
               end
            end
            HACC: begin
               if (!addr_ok) begin
                  Int <= 1'b1;
                  if (!hwr_q) DataOut <= ERR_DATA;
               end else if (hwr_q && (addr_q == INT_CLR_ADDR)) begin
                  Int <= 1'b0;
               end
            end
            HRD:     DataOut <= RegRdata;
            IACC:    iwe_q   <= IWe;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fburg_bus_arb.sv
// Self-checking bench for fburg_bus_arb: directed scenarios plus randomized host/internal traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_fburg_bus_arb;

   localparam logic [15:0] ERR = 16'hdead;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [11:0] Addr;
   logic [15:0] DataIn;
   logic [15:0] DataOut;
   logic        DataOe;
   logic        Cs, Rd, Wr;
   logic        WaitN, WaitOe, Int;
   logic        IReq, IWe;
   logic [5:0]  IAddr;
   logic [15:0] IWdata;
   logic        IGnt, IValid;
   logic [15:0] IRdata;
   logic        RegEn, RegWe;
   logic [5:0]  RegAddr;
   logic [15:0] RegWdata;
   logic [15:0] RegRdata;

   always #5 Clk = ~Clk;

   fburg_bus_arb dut (
      .Clk(Clk), .Reset(Reset), .Addr(Addr), .DataIn(DataIn), .DataOut(DataOut),
      .DataOe(DataOe), .Cs(Cs), .Rd(Rd), .Wr(Wr), .WaitN(WaitN), .WaitOe(WaitOe),
      .Int(Int), .IReq(IReq), .IWe(IWe), .IAddr(IAddr), .IWdata(IWdata),
      .IGnt(IGnt), .IValid(IValid), .IRdata(IRdata), .RegEn(RegEn), .RegWe(RegWe),
      .RegAddr(RegAddr), .RegWdata(RegWdata), .RegRdata(RegRdata)
   );

   // Register file attached to the shared port: read data one cycle after RegEn.
   logic [15:0] regmem [64];
   logic [15:0] rd_q;
   logic        clr_mem;
   always @(posedge Clk) begin
      if (clr_mem) begin
         for (int i = 0; i < 64; i++) regmem[i] <= '0;
         rd_q <= '0;
      end else if (RegEn) begin
         if (RegWe) regmem[RegAddr] <= RegWdata;
         rd_q <= regmem[RegAddr];
      end
   end
   assign RegRdata = rd_q;

   // Event monitor, sampled mid-cycle.
   int          regen_cnt = 0;
   int          gnt_cnt   = 0;
   int          vld_cnt   = 0;
   logic [5:0]  last_ra;
   logic        last_we;
   logic [15:0] last_wd;
   always @(negedge Clk) begin
      if (RegEn) begin
         regen_cnt++;
         last_ra = RegAddr;
         last_we = RegWe;
         last_wd = RegWdata;
      end
      if (IGnt)   gnt_cnt++;
      if (IValid) vld_cnt++;
   end

   // Reference model state: register contents as the spec says they should be.
   logic [15:0] ref_mem [64];
   logic        int_exp;
   logic [15:0] dout_exp;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // One complete host bus cycle; expectations come from the spec's rules.
   task automatic host_op(input bit wr, input logic [11:0] a, input logic [15:0] d,
                          input bit both, input int hold);
      bit         legal;
      logic [5:0] word;
      int         exp_low, exp_en, low, en0;
      bit         done;
      legal = (a[0] == 1'b0) && (a[11:7] == 5'd0);
      word  = a[6:1];
      if (both) begin
         exp_low = 1; exp_en = 0; int_exp = 1'b1;
      end else if (!legal) begin
         exp_low = 2; exp_en = 0; int_exp = 1'b1;
         if (!wr) dout_exp = ERR;
      end else if (wr) begin
         exp_low = 2; exp_en = 1; ref_mem[word] = d;
         if (word == 6'd0) int_exp = 1'b0;
      end else begin
         exp_low = 3; exp_en = 1; dout_exp = ref_mem[word];
      end
      en0 = regen_cnt;
      Addr = a; DataIn = d; Cs = 1'b0;
      Rd = !(both || !wr);
      Wr = !(both || wr);
      low = 0; done = 0;
      for (int b = 0; b < 30 && !done; b++) begin
         tick();
         if (WaitOe && !WaitN) low++;
         if (WaitOe && WaitN) done = 1;
      end
      chk("host_done", done, 1);
      chk("host_dataoe", DataOe, (!wr || both));
      for (int h = 0; h < hold; h++) begin
         tick();
         if (WaitOe && !WaitN) low++;
      end
      Cs = 1'b1; Rd = 1'b1; Wr = 1'b1;
      done = 0;
      for (int b = 0; b < 10 && !done; b++) begin
         tick();
         if (!WaitOe) done = 1;
      end
      chk("host_release", done, 1);
      tick();
      chk("host_waitn_low_cycles", low, exp_low);
      chk("host_regen_count", regen_cnt - en0, exp_en);
      chk("host_int", Int, int_exp);
      if (!both && !wr) chk("host_dataout", DataOut, dout_exp);
      if (exp_en == 1) begin
         chk("host_regaddr", last_ra, word);
         chk("host_regwe", last_we, wr);
         if (wr) chk("host_regwdata", last_wd, d);
      end
   endtask

   // One internal access starting from an idle arbiter.
   task automatic int_op(input bit we, input logic [5:0] a, input logic [15:0] d);
      bit got;
      int v0;
      IReq = 1'b1; IWe = we; IAddr = a; IWdata = d;
      got = 0;
      for (int b = 0; b < 20 && !got; b++) begin
         tick();
         if (IGnt) got = 1;
      end
      chk("int_gnt", got, 1);
      IReq = 1'b0;
      v0 = vld_cnt;
      tick();
      chk("int_valid", IValid, !we);
      if (!we) chk("int_rdata", IRdata, ref_mem[a]);
      tick();
      chk("int_valid_pulses", vld_cnt - v0, !we);
      if (we) ref_mem[a] = d;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit          got;
      bit          done;
      int          low, en0, g0, kind;
      logic [5:0]  w;
      logic [11:0] ia;

      for (int i = 0; i < 64; i++) ref_mem[i] = '0;
      int_exp = 1'b0; dout_exp = '0;
      Reset = 1'b1; clr_mem = 1'b1;
      Addr = '0; DataIn = '0; Cs = 1'b1; Rd = 1'b1; Wr = 1'b1;
      IReq = 1'b0; IWe = 1'b0; IAddr = '0; IWdata = '0;
      repeat (3) tick();
      clr_mem = 1'b0;
      Reset = 1'b0;
      tick();

      // Reset state.
      chk("rst_dataout", DataOut, 16'h0);
      chk("rst_waitn", WaitN, 1);
      chk("rst_waitoe", WaitOe, 0);
      chk("rst_int", Int, 0);
      chk("rst_ignt", IGnt, 0);
      chk("rst_ivalid", IValid, 0);
      chk("rst_regen", RegEn, 0);
      chk("rst_regwe", RegWe, 0);
      chk("rst_dataoe", DataOe, 0);

      // Basic write then read of byte 0x004 (word 2).
      host_op(1'b1, 12'h004, 16'h1234, 1'b0, 0);
      host_op(1'b0, 12'h004, 16'h0000, 1'b0, 0);
      chk("wr_rd_dataout_1234", DataOut, 16'h1234);

      // Odd address read is rejected; write to 0x000 clears Int.
      host_op(1'b0, 12'h003, 16'h0000, 1'b0, 0);
      chk("odd_read_err", DataOut, 16'hdead);
      host_op(1'b1, 12'h000, 16'h5a5a, 1'b0, 0);
      chk("int_cleared", Int, 0);

      // Rd and Wr both low, strobes held 20 extra cycles: one flagged access only.
      host_op(1'b0, 12'h010, 16'h0000, 1'b1, 20);
      host_op(1'b1, 12'h000, 16'h0001, 1'b0, 0);

      // Contention: internal grant first, then host and IReq both pending in IDLE.
      IReq = 1'b1; IWe = 1'b0; IAddr = 6'd2; IWdata = '0;
      got = 0;
      for (int b = 0; b < 20 && !got; b++) begin
         tick();
         if (IGnt) got = 1;
      end
      chk("arb_first_gnt", got, 1);
      Addr = 12'h004; Cs = 1'b0; Rd = 1'b0;
      tick();
      tick();
      chk("arb_host_wins", WaitOe && !WaitN, 1);
      chk("arb_no_gnt_on_host_win", IGnt, 0);
      g0 = gnt_cnt;
      done = 0;
      for (int b = 0; b < 20 && !done; b++) begin
         tick();
         if (WaitOe && WaitN) done = 1;
      end
      chk("arb_host_done", done, 1);
      chk("arb_no_gnt_during_host", gnt_cnt - g0, 0);
      chk("arb_host_dataout", DataOut, ref_mem[2]);
      Cs = 1'b1; Rd = 1'b1;
      got = 0;
      for (int b = 0; b < 20 && !got; b++) begin
         tick();
         if (IGnt) got = 1;
      end
      chk("arb_int_gnt_after_host", got, 1);
      IReq = 1'b0;
      tick();
      chk("arb_ivalid_after_gnt", IValid, 1);
      chk("arb_irdata", IRdata, ref_mem[2]);
      tick();

      // Reset during HRD aborts; the still-held read is served again after reset.
      en0 = regen_cnt;
      Addr = 12'h004; Cs = 1'b0; Rd = 1'b0;
      low = 0;
      for (int b = 0; b < 20 && low < 3; b++) begin
         tick();
         if (WaitOe && !WaitN) low++;
      end
      chk("rst_mid_reached_hrd", low, 3);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      int_exp = 1'b0;
      chk("rst_mid_waitoe", WaitOe, 0);
      chk("rst_mid_waitn", WaitN, 1);
      chk("rst_mid_dataout", DataOut, 16'h0);
      low = 0; done = 0;
      for (int b = 0; b < 20 && !done; b++) begin
         tick();
         if (WaitOe && !WaitN) low++;
         if (WaitOe && WaitN) done = 1;
      end
      chk("rst_mid_reserved", done, 1);
      chk("rst_mid_reserve_latency", low, 3);
      chk("rst_mid_dataout_after", DataOut, ref_mem[2]);
      Cs = 1'b1; Rd = 1'b1;
      done = 0;
      for (int b = 0; b < 10 && !done; b++) begin
         tick();
         if (!WaitOe) done = 1;
      end
      chk("rst_mid_release", done, 1);
      tick();
      chk("rst_mid_regen_total", regen_cnt - en0, 2);
      dout_exp = ref_mem[2];

      // Randomized mix of host and internal traffic.
      for (int n = 0; n < 40; n++) begin
         kind = int'($urandom_range(0, 5));
         w = 6'($urandom_range(0, 63));
         if ($urandom_range(0, 7) == 0) w = 6'd0;
         case (kind)
            0, 1: host_op(1'b1, {5'b0, w, 1'b0}, 16'($urandom), 1'b0, int'($urandom_range(0, 2)));
            2:    host_op(1'b0, {5'b0, w, 1'b0}, 16'h0, 1'b0, int'($urandom_range(0, 2)));
            3: begin
               ia = 12'($urandom);
               if ($urandom_range(0, 1) == 0) ia[0] = 1'b1;
               else ia[11:7] = ia[11:7] | 5'(1 << $urandom_range(0, 4));
               host_op(1'($urandom_range(0, 1)), ia, 16'($urandom), 1'b0, 0);
            end
            4:       int_op(1'b1, w, 16'($urandom));
            default: int_op(1'b0, w, 16'h0);
         endcase
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
